// File: rtl/psmac_operand_packer.sv
// psmac_operand_packer: gathers 2/4/8-bit activation/weight element pairs
// into 32-bit packed MAC operand words with per-digit sign flags and
// precision controls, handing each word out over a valid/ready handshake.
module psmac_operand_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_act,
  input  logic [7:0]  in_wt,
  input  logic        in_act_signed,
  input  logic        in_wt_signed,
  input  logic [1:0]  in_prec,
  input  logic        flush,
  output logic [31:0] ip,
  output logic [31:0] wt,
  output logic [3:0]  sx1,
  output logic [3:0]  sx2,
  output logic [3:0]  sx3,
  output logic [3:0]  sx4,
  output logic [3:0]  sy1,
  output logic [3:0]  sy2,
  output logic [3:0]  sy3,
  output logic [3:0]  sy4,
  output logic        mode1,
  output logic        mode2,
  output logic [4:0]  out_count,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {
    PREC_8 = 2'b00,
    PREC_4 = 2'b01,
    PREC_2 = 2'b10
  } prec_t;

  // group (assembly) state
  logic [3:0]  cnt_reg;
  prec_t       grp_prec_reg;
  logic [31:0] asm_ip_reg;
  logic [31:0] asm_wt_reg;
  logic [15:0] asm_sx_reg;
  logic [15:0] asm_sy_reg;

  // issued word state
  logic [31:0] ip_reg;
  logic [31:0] wt_reg;
  logic [15:0] sx_reg;
  logic [15:0] sy_reg;
  logic        mode1_reg;
  logic        mode2_reg;
  logic [4:0]  out_count_reg;
  logic        out_valid_reg;

  // decoded beat information
  prec_t       in_prec_norm;
  prec_t       eff_prec;
  logic [3:0]  last_idx;
  logic [4:0]  word_n;
  logic [4:0]  shamt;
  logic [3:0]  top_digit;
  logic [31:0] act_elem;
  logic [31:0] wt_elem;
  logic        mode1_c;
  logic        mode2_c;
  logic [15:0] act_sgn_place;
  logic [15:0] wt_sgn_place;
  logic [31:0] ip_next;
  logic [31:0] wt_next;
  logic [15:0] sx_next;
  logic [15:0] sy_next;
  logic        out_free;
  logic        accept;
  logic        complete;
  logic        flush_issue;

  // reserved precision code 11 behaves as 8-bit
  assign in_prec_norm = (in_prec == 2'b01) ? PREC_4 :
                        (in_prec == 2'b10) ? PREC_2 : PREC_8;

  // the first beat of a group decides its precision; later beats follow the latch
  assign eff_prec = (cnt_reg == 4'd0) ? in_prec_norm : grp_prec_reg;

  // per-precision element geometry and MAC mode controls
  always_comb begin
    last_idx  = 4'd3;
    word_n    = 5'd4;
    shamt     = {cnt_reg[1:0], 3'b000};
    top_digit = {cnt_reg[1:0], 2'b11};
    act_elem  = {24'd0, in_act};
    wt_elem   = {24'd0, in_wt};
    mode1_c   = 1'b1;
    mode2_c   = 1'b1;
    case (eff_prec)
      PREC_4: begin
        last_idx  = 4'd7;
        word_n    = 5'd8;
        shamt     = {cnt_reg[2:0], 2'b00};
        top_digit = {cnt_reg[2:0], 1'b1};
        act_elem  = {28'd0, in_act[3:0]};
        wt_elem   = {28'd0, in_wt[3:0]};
        mode1_c   = 1'b1;
        mode2_c   = 1'b0;
      end
      PREC_2: begin
        last_idx  = 4'd15;
        word_n    = 5'd16;
        shamt     = {cnt_reg, 1'b0};
        top_digit = cnt_reg;
        act_elem  = {30'd0, in_act[1:0]};
        wt_elem   = {30'd0, in_wt[1:0]};
        mode1_c   = 1'b0;
        mode2_c   = 1'b0;
      end
      default: ;
    endcase
  end

  // sign flag lands only on the element's top digit
  for (genvar gi = 0; gi < 16; gi++) begin : g_sign_place
    assign act_sgn_place[gi] = in_act_signed && (top_digit == 4'(gi));
    assign wt_sgn_place[gi]  = in_wt_signed  && (top_digit == 4'(gi));
  end

  // a fresh group starts from an empty word so stale bits never leak in
  assign ip_next = ((cnt_reg == 4'd0) ? 32'd0 : asm_ip_reg) | (act_elem << shamt);
  assign wt_next = ((cnt_reg == 4'd0) ? 32'd0 : asm_wt_reg) | (wt_elem << shamt);
  assign sx_next = ((cnt_reg == 4'd0) ? 16'd0 : asm_sx_reg) | act_sgn_place;
  assign sy_next = ((cnt_reg == 4'd0) ? 16'd0 : asm_sy_reg) | wt_sgn_place;

  assign out_free    = !out_valid_reg || out_ready;
  // only the completing beat can stall, since it needs the output register
  assign in_ready    = !flush && !((cnt_reg == last_idx) && out_valid_reg && !out_ready);
  assign accept      = in_valid && in_ready;
  assign complete    = accept && (cnt_reg == last_idx);
  assign flush_issue = flush && (cnt_reg != 4'd0) && out_free;

  // assembly register and element counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg      <= 4'd0;
      grp_prec_reg <= PREC_8;
      asm_ip_reg   <= 32'd0;
      asm_wt_reg   <= 32'd0;
      asm_sx_reg   <= 16'd0;
      asm_sy_reg   <= 16'd0;
    end else if (complete || flush_issue) begin
      cnt_reg    <= 4'd0;
      asm_ip_reg <= 32'd0;
      asm_wt_reg <= 32'd0;
      asm_sx_reg <= 16'd0;
      asm_sy_reg <= 16'd0;
    end else if (accept) begin
      cnt_reg    <= cnt_reg + 4'd1;
      asm_ip_reg <= ip_next;
      asm_wt_reg <= wt_next;
      asm_sx_reg <= sx_next;
      asm_sy_reg <= sy_next;
      if (cnt_reg == 4'd0) grp_prec_reg <= eff_prec;
    end
  end

  // output word register: loads on completion or flush, holds under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ip_reg        <= 32'd0;
      wt_reg        <= 32'd0;
      sx_reg        <= 16'd0;
      sy_reg        <= 16'd0;
      mode1_reg     <= 1'b0;
      mode2_reg     <= 1'b0;
      out_count_reg <= 5'd0;
      out_valid_reg <= 1'b0;
    end else if (complete) begin
      ip_reg        <= ip_next;
      wt_reg        <= wt_next;
      sx_reg        <= sx_next;
      sy_reg        <= sy_next;
      mode1_reg     <= mode1_c;
      mode2_reg     <= mode2_c;
      out_count_reg <= word_n;
      out_valid_reg <= 1'b1;
    end else if (flush_issue) begin
      ip_reg        <= asm_ip_reg;
      wt_reg        <= asm_wt_reg;
      sx_reg        <= asm_sx_reg;
      sy_reg        <= asm_sy_reg;
      mode1_reg     <= mode1_c;
      mode2_reg     <= mode2_c;
      out_count_reg <= {1'b0, cnt_reg};
      out_valid_reg <= 1'b1;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign ip                   = ip_reg;
  assign wt                   = wt_reg;
  assign {sx4, sx3, sx2, sx1} = sx_reg;
  assign {sy4, sy3, sy2, sy1} = sy_reg;
  assign mode1                = mode1_reg;
  assign mode2                = mode2_reg;
  assign out_count            = out_count_reg;
  assign out_valid            = out_valid_reg;

endmodule

// File: tb/tb_psmac_operand_packer.sv
// Directed bench for psmac_operand_packer: packing in all precisions,
// backpressure, flush and mid-group reset.
module tb_psmac_operand_packer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_act;
  logic [7:0]  in_wt;
  logic        in_act_signed;
  logic        in_wt_signed;
  logic [1:0]  in_prec;
  logic        flush;
  logic [31:0] ip;
  logic [31:0] wt;
  logic [3:0]  sx1, sx2, sx3, sx4;
  logic [3:0]  sy1, sy2, sy3, sy4;
  logic        mode1;
  logic        mode2;
  logic [4:0]  out_count;
  logic        out_valid;
  logic        out_ready;

  int total = 0;
  int bad   = 0;

  psmac_operand_packer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_act        (in_act),
    .in_wt         (in_wt),
    .in_act_signed (in_act_signed),
    .in_wt_signed  (in_wt_signed),
    .in_prec       (in_prec),
    .flush         (flush),
    .ip            (ip),
    .wt            (wt),
    .sx1           (sx1),
    .sx2           (sx2),
    .sx3           (sx3),
    .sx4           (sx4),
    .sy1           (sy1),
    .sy2           (sy2),
    .sy3           (sy3),
    .sy4           (sy4),
    .mode1         (mode1),
    .mode2         (mode2),
    .out_count     (out_count),
    .out_valid     (out_valid),
    .out_ready     (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one beat held for exactly one rising edge, inputs changed 1 time unit after it
  task automatic send(input logic [7:0] a, input logic [7:0] w,
                      input logic as, input logic ws, input logic [1:0] p);
    in_act        = a;
    in_wt         = w;
    in_act_signed = as;
    in_wt_signed  = ws;
    in_prec       = p;
    in_valid      = 1'b1;
    @(posedge clk); #1;
    in_valid      = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_act = 8'd0; in_wt = 8'd0;
    in_act_signed = 1'b0; in_wt_signed = 1'b0; in_prec = 2'b00;
    flush = 1'b0; out_ready = 1'b0;

    // reset state
    repeat (2) @(posedge clk); #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_ip",        ip,             32'd0);
    chk("rst_wt",        wt,             32'd0);
    chk("rst_sx",        32'({sx4, sx3, sx2, sx1}), 32'd0);
    chk("rst_sy",        32'({sy4, sy3, sy2, sy1}), 32'd0);
    chk("rst_modes",     32'({mode1, mode2}), 32'd0);
    chk("rst_count",     32'(out_count), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 8-bit, all signed
    send(8'h81, 8'hFF, 1'b1, 1'b1, 2'b00);
    send(8'h02, 8'h01, 1'b1, 1'b1, 2'b00);
    send(8'h03, 8'h7F, 1'b1, 1'b1, 2'b00);
    chk("b8_not_yet_valid", 32'(out_valid), 32'd0);
    send(8'h04, 8'h80, 1'b1, 1'b1, 2'b00);
    $display("txn b8: ip=%h wt=%h cnt=%0d", ip, wt, out_count);
    chk("b8_valid", 32'(out_valid), 32'd1);
    chk("b8_ip",    ip, 32'h04030281);
    chk("b8_wt",    wt, 32'h807F01FF);
    chk("b8_sx",    32'({sx4, sx3, sx2, sx1}), 32'h8888);
    chk("b8_sy",    32'({sy4, sy3, sy2, sy1}), 32'h8888);
    chk("b8_modes", 32'({mode1, mode2}), 32'd3);
    chk("b8_count", 32'(out_count), 32'd4);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("b8_drained", 32'(out_valid), 32'd0);

    // 2-bit unsigned; later beats carry a different in_prec that must be ignored
    for (int i = 0; i < 16; i++)
      send(8'(i % 4), 8'h03, 1'b0, 1'b0, (i == 0) ? 2'b10 : 2'b01);
    $display("txn b2: ip=%h wt=%h cnt=%0d", ip, wt, out_count);
    chk("b2_valid", 32'(out_valid), 32'd1);
    chk("b2_ip",    ip, 32'hE4E4E4E4);
    chk("b2_wt",    wt, 32'hFFFFFFFF);
    chk("b2_sx",    32'({sx4, sx3, sx2, sx1}), 32'd0);
    chk("b2_sy",    32'({sy4, sy3, sy2, sy1}), 32'd0);
    chk("b2_modes", 32'({mode1, mode2}), 32'd0);
    chk("b2_count", 32'(out_count), 32'd16);
    @(posedge clk); #1;
    chk("b2_drained", 32'(out_valid), 32'd0);

    // 4-bit, activation signedness alternating 1,0; later beats carry code 11
    for (int i = 0; i < 8; i++)
      send(8'(i + 1), 8'h00, (i % 2) == 0, 1'b0, (i == 0) ? 2'b01 : 2'b11);
    $display("txn b4: ip=%h wt=%h cnt=%0d", ip, wt, out_count);
    chk("b4_ip",    ip, 32'h87654321);
    chk("b4_sx",    32'({sx4, sx3, sx2, sx1}), 32'h2222);
    chk("b4_sy",    32'({sy4, sy3, sy2, sy1}), 32'd0);
    chk("b4_modes", 32'({mode1, mode2}), 32'd2);
    chk("b4_count", 32'(out_count), 32'd8);
    @(posedge clk); #1;

    // backpressure: held word, next group stalls on its completing beat
    out_ready = 1'b0;
    send(8'h10, 8'h20, 1'b0, 1'b0, 2'b00);
    send(8'h11, 8'h21, 1'b0, 1'b0, 2'b00);
    send(8'h12, 8'h22, 1'b0, 1'b0, 2'b00);
    send(8'h13, 8'h23, 1'b0, 1'b0, 2'b00);
    chk("bp_first_ip", ip, 32'h13121110);
    send(8'hA0, 8'hB0, 1'b1, 1'b1, 2'b00);
    send(8'hA1, 8'hB1, 1'b1, 1'b1, 2'b00);
    send(8'hA2, 8'hB2, 1'b1, 1'b1, 2'b00);
    in_act = 8'hA3; in_wt = 8'hB3; in_act_signed = 1'b1; in_wt_signed = 1'b1;
    in_prec = 2'b00; in_valid = 1'b1;
    #1;
    chk("bp_stall_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    chk("bp_hold_ip",    ip, 32'h13121110);
    chk("bp_hold_wt",    wt, 32'h23222120);
    chk("bp_hold_sx",    32'({sx4, sx3, sx2, sx1}), 32'd0);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    $display("txn bp: ip=%h wt=%h cnt=%0d", ip, wt, out_count);
    chk("bp_next_valid", 32'(out_valid), 32'd1);
    chk("bp_next_ip",    ip, 32'hA3A2A1A0);
    chk("bp_next_wt",    wt, 32'hB3B2B1B0);
    chk("bp_next_sx",    32'({sx4, sx3, sx2, sx1}), 32'h8888);
    chk("bp_next_sy",    32'({sy4, sy3, sy2, sy1}), 32'h8888);
    chk("bp_next_count", 32'(out_count), 32'd4);
    @(posedge clk); #1;
    chk("bp_drained", 32'(out_valid), 32'd0);

    // flush of a two-element 8-bit partial word; a beat offered during flush is refused
    send(8'h11, 8'h00, 1'b1, 1'b0, 2'b00);
    send(8'h22, 8'h00, 1'b1, 1'b0, 2'b00);
    flush = 1'b1;
    in_act = 8'h33; in_wt = 8'h44; in_valid = 1'b1;
    #1;
    chk("fl_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush = 1'b0;
    $display("txn fl: ip=%h wt=%h cnt=%0d", ip, wt, out_count);
    chk("fl_valid", 32'(out_valid), 32'd1);
    chk("fl_ip",    ip, 32'h00002211);
    chk("fl_wt",    wt, 32'd0);
    chk("fl_sx",    32'({sx4, sx3, sx2, sx1}), 32'h0088);
    chk("fl_count", 32'(out_count), 32'd2);
    chk("fl_modes", 32'({mode1, mode2}), 32'd3);
    // flush with an empty group must not reissue anything
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("fl_empty_noissue", 32'(out_valid), 32'd0);

    // reset mid-group, then a fresh group using reserved code 11 (8-bit)
    send(8'h55, 8'h66, 1'b1, 1'b1, 2'b00);
    send(8'h77, 8'h88, 1'b1, 1'b1, 2'b00);
    rst_n = 1'b0;
    #2;
    chk("mr_ip",    ip, 32'd0);
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_count", 32'(out_count), 32'd0);
    chk("mr_modes", 32'({mode1, mode2}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(8'h01, 8'h0D, 1'b0, 1'b0, 2'b11);
    send(8'h02, 8'h0C, 1'b0, 1'b0, 2'b11);
    send(8'h03, 8'h0B, 1'b0, 1'b0, 2'b11);
    send(8'h04, 8'h0A, 1'b0, 1'b0, 2'b11);
    $display("txn mr: ip=%h wt=%h cnt=%0d", ip, wt, out_count);
    chk("mr_new_valid", 32'(out_valid), 32'd1);
    chk("mr_new_ip",    ip, 32'h04030201);
    chk("mr_new_wt",    wt, 32'h0A0B0C0D);
    chk("mr_new_sx",    32'({sx4, sx3, sx2, sx1}), 32'd0);
    chk("mr_new_count", 32'(out_count), 32'd4);
    chk("mr_new_modes", 32'({mode1, mode2}), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
